// File: rtl/uart_pkg.sv
// Shared types for the uDMA UART receive/transmit line helpers.
// Holds the RX conditioner state encoding and the glitch counter width.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_DIS,
    RX_HIGH,
    RX_LOW,
    RX_BRK
  } uart_rx_cond_state_e;

  localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/udma_uart_sync.sv
// Reset-to-one flop chain bringing an asynchronous pad level into the local clock.
// Latency STAGES cycles; no backpressure (free-running every cycle).
module udma_uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Reset to 1 so an idle UART line is not seen as a start bit after reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/udma_uart_rx_cond.sv
// UART RX pad conditioner: synchroniser, glitch filter, break/idle detection, glitch counter.
// Pad-to-rx_o latency SYNC_STAGES + max(N,1) cycles; all outputs registered, no backpressure.
module udma_uart_rx_cond
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                periph_clk_i,
  input  logic                rstn_i,
  input  logic                cfg_en_i,
  input  logic [FILT_W-1:0]   cfg_filt_len_i,
  input  logic [CNT_W-1:0]    cfg_break_len_i,
  input  logic [CNT_W-1:0]    cfg_idle_len_i,
  input  logic                glitch_clr_i,
  input  logic                rx_i,
  output logic                rx_o,
  output logic                break_o,
  output logic                break_evt_o,
  output logic                idle_evt_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  logic                s;
  uart_rx_cond_state_e state_q, state_d;
  logic [FILT_W-1:0]   fc_q, fc_d;
  logic [CNT_W-1:0]    rc_q, rc_d;
  logic [FILT_W:0]     n_eff, fc_inc;
  logic [CNT_W:0]      run_len;
  logic                active, rx_d, glitch_inc;
  logic                armed_q, armed_d;
  logic                brk_hit, idle_now, brk_evt_d, idle_evt_d;

  udma_uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (periph_clk_i),
    .rstn_i (rstn_i),
    .d_i    (rx_i),
    .q_o    (s)
  );

  // The DIS->HIGH cycle is spent settling, so the filter starts from a clean slate.
  assign active = cfg_en_i && (state_q != RX_DIS);
  assign n_eff  = (cfg_filt_len_i == '0) ? (FILT_W+1)'(1) : {1'b0, cfg_filt_len_i};
  assign fc_inc = {1'b0, fc_q} + (FILT_W+1)'(1);

  always_comb begin
    fc_d       = '0;
    rx_d       = 1'b1;
    glitch_inc = 1'b0;
    if (active) begin
      rx_d = rx_o;
      if (s == rx_o) begin
        glitch_inc = (fc_q != '0);
      end else if (fc_inc >= n_eff) begin
        rx_d = s;
      end else begin
        fc_d = fc_inc[FILT_W-1:0];
      end
    end
  end

  always_comb begin
    if (!active || (rx_d != rx_o)) begin
      rc_d = '0;
    end else if (&rc_q) begin
      rc_d = rc_q;
    end else begin
      rc_d = rc_q + CNT_W'(1);
    end
  end

  // Compare against the run length of the cycle being entered, so registered events land on it.
  assign run_len  = {1'b0, rc_d} + (CNT_W+1)'(1);
  assign brk_hit  = (cfg_break_len_i != '0) && (run_len == {1'b0, cfg_break_len_i});
  assign idle_now = armed_q && (cfg_idle_len_i != '0) && (run_len == {1'b0, cfg_idle_len_i});

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    brk_evt_d  = 1'b0;
    idle_evt_d = 1'b0;
    if (!cfg_en_i) begin
      state_d = RX_DIS;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        RX_DIS: begin
          state_d = RX_HIGH;
        end
        RX_HIGH: begin
          if (rx_d) begin
            idle_evt_d = idle_now;
            armed_d    = armed_q && !idle_now;
          end else begin
            armed_d   = 1'b1;
            brk_evt_d = brk_hit;
            state_d   = brk_hit ? RX_BRK : RX_LOW;
          end
        end
        RX_LOW: begin
          if (rx_d) begin
            state_d    = RX_HIGH;
            idle_evt_d = idle_now;
            armed_d    = armed_q && !idle_now;
          end else if (brk_hit) begin
            state_d   = RX_BRK;
            brk_evt_d = 1'b1;
          end
        end
        RX_BRK: begin
          if (rx_d) begin
            state_d    = RX_HIGH;
            idle_evt_d = idle_now;
            armed_d    = armed_q && !idle_now;
          end
        end
        default: begin
          state_d = RX_DIS;
        end
      endcase
    end
  end

  always_ff @(posedge periph_clk_i) begin
    if (!rstn_i) begin
      state_q     <= RX_DIS;
      fc_q        <= '0;
      rc_q        <= '0;
      armed_q     <= 1'b0;
      rx_o        <= 1'b1;
      break_o     <= 1'b0;
      break_evt_o <= 1'b0;
      idle_evt_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      rc_q        <= rc_d;
      armed_q     <= armed_d;
      rx_o        <= rx_d;
      break_o     <= (state_d == RX_BRK);
      break_evt_o <= brk_evt_d;
      idle_evt_o  <= idle_evt_d;
    end
  end

  always_ff @(posedge periph_clk_i) begin
    if (!rstn_i || glitch_clr_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch_inc && !(&glitch_cnt_o)) begin
      glitch_cnt_o <= glitch_cnt_o + GLITCH_W'(1);
    end
  end

endmodule

// File: tb/tb_udma_uart_rx_cond.sv
// Randomised and directed bench for udma_uart_rx_cond against a run-length reference model.
module tb_udma_uart_rx_cond;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_W      = 4;
  localparam int CNT_W       = 16;
  localparam int RUN_MAX     = 1 << CNT_W;

  logic              periph_clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              cfg_en_i = 1'b0;
  logic [FILT_W-1:0] cfg_filt_len_i = 4'd3;
  logic [CNT_W-1:0]  cfg_break_len_i = '0;
  logic [CNT_W-1:0]  cfg_idle_len_i = '0;
  logic              glitch_clr_i = 1'b0;
  logic              rx_i = 1'b1;
  logic              rx_o, break_o, break_evt_o, idle_evt_o;
  logic [7:0]        glitch_cnt_o;

  udma_uart_rx_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W),
    .CNT_W       (CNT_W)
  ) dut (
    .periph_clk_i    (periph_clk_i),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_filt_len_i  (cfg_filt_len_i),
    .cfg_break_len_i (cfg_break_len_i),
    .cfg_idle_len_i  (cfg_idle_len_i),
    .glitch_clr_i    (glitch_clr_i),
    .rx_i            (rx_i),
    .rx_o            (rx_o),
    .break_o         (break_o),
    .break_evt_o     (break_evt_o),
    .idle_evt_o      (idle_evt_o),
    .glitch_cnt_o    (glitch_cnt_o)
  );

  always #5 periph_clk_i = ~periph_clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad history queue, line level, length of the current
  // disagreement streak and of the current level run (in cycles, this one included).
  bit padq[$];
  bit m_line, m_armed, m_brk, m_on, m_bevt, m_ievt;
  int m_dis, m_run, m_glitch;

  task automatic m_reset();
    padq.delete();
    for (int i = 0; i < SYNC_STAGES; i++) padq.push_back(1'b1);
    m_line = 1; m_dis = 0; m_run = 1; m_armed = 0; m_brk = 0; m_on = 0;
    m_glitch = 0; m_bevt = 0; m_ievt = 0;
  endtask

  task automatic m_edge();
    bit s, chg;
    int neff, blen, ilen;
    m_bevt = 0;
    m_ievt = 0;
    if (!rstn_i) begin
      m_reset();
      return;
    end
    s = padq.pop_front();
    padq.push_back(rx_i);
    neff = (cfg_filt_len_i == 0) ? 1 : int'(cfg_filt_len_i);
    blen = int'(cfg_break_len_i);
    ilen = int'(cfg_idle_len_i);
    if (!(cfg_en_i && m_on)) begin
      m_line = 1; m_dis = 0; m_run = 1; m_armed = 0; m_brk = 0;
    end else begin
      chg = 0;
      if (s == m_line) begin
        if (m_dis > 0) m_glitch = (m_glitch < 255) ? m_glitch + 1 : 255;
        m_dis = 0;
      end else begin
        m_dis++;
        if (m_dis >= neff) begin
          m_line = s;
          m_dis = 0;
          chg = 1;
        end
      end
      m_run = chg ? 1 : ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX);
      if (chg && !m_line) m_armed = 1;
      if (!m_line && !m_brk && blen != 0 && m_run == blen) begin
        m_bevt = 1;
        m_brk = 1;
      end
      if (m_line) m_brk = 0;
      if (m_line && m_armed && ilen != 0 && m_run == ilen) begin
        m_ievt = 1;
        m_armed = 0;
      end
    end
    m_on = cfg_en_i;
    if (glitch_clr_i) m_glitch = 0;
  endtask

  task automatic step();
    @(posedge periph_clk_i);
    m_edge();
    #1;
    chk("rx_o", rx_o, m_line);
    chk("break_o", break_o, m_brk);
    chk("break_evt_o", break_evt_o, m_bevt);
    chk("idle_evt_o", idle_evt_o, m_ievt);
    chk("glitch_cnt_o", glitch_cnt_o, m_glitch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, bpos, lowcnt, ni, ipos, hirun, run_left;
    bit prev_rx, rise_seen, lvl;
    logic [9:0] frame;
    m_reset();

    // Reset and defaults
    repeat (3) step();
    chk("rst_rx", rx_o, 1);
    chk("rst_glitch", glitch_cnt_o, 0);
    rstn_i = 1; cfg_en_i = 1; cfg_filt_len_i = 3;
    repeat (10) step();
    chk("dflt_rx", rx_o, 1);
    chk("dflt_brk", break_o, 0);

    // Glitch rejection and saturation
    for (int i = 0; i < 300; i++) begin
      rx_i = 0; repeat (2) step();
      rx_i = 1; repeat (3) step();
      if (i == 0) chk("glitch_one", glitch_cnt_o, 1);
      if (i == 0) chk("glitch_rx_held", rx_o, 1);
    end
    chk("glitch_sat", glitch_cnt_o, 255);
    glitch_clr_i = 1; step(); glitch_clr_i = 0;
    chk("glitch_clr", glitch_cnt_o, 0);

    // Pad-to-output latency
    rx_i = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!rx_o && lat < 0) lat = i;
    end
    chk("latency", lat, 5);
    rx_i = 1; repeat (10) step();

    // Break detection and release
    cfg_break_len_i = 20; nb = 0; bpos = 0; lowcnt = 0; prev_rx = 1; rise_seen = 0;
    for (int i = 0; i < 70; i++) begin
      rx_i = (i < 50) ? 1'b0 : 1'b1;
      step();
      if (!rx_o) lowcnt++;
      if (break_evt_o) begin nb++; bpos = lowcnt; end
      if (lowcnt == 30 && !rx_o) chk("brk_level", break_o, 1);
      if (!prev_rx && rx_o) begin
        rise_seen = 1;
        chk("brk_drop", break_o, 0);
      end
      prev_rx = rx_o;
    end
    chk("brk_count", nb, 1);
    chk("brk_pos", bpos, 20);
    chk("brk_rise_seen", rise_seen, 1);

    // Idle: none after reset, then exactly one after a 0x55 frame
    rstn_i = 0; repeat (2) step(); rstn_i = 1;
    cfg_idle_len_i = 16; ni = 0;
    repeat (40) begin step(); if (idle_evt_o) ni++; end
    chk("idle_after_rst", ni, 0);
    frame = {1'b1, 8'h55, 1'b0};
    ni = 0; ipos = 0; hirun = 0;
    for (int b = 0; b < 70; b++) begin
      rx_i = (b < 10) ? frame[b] : 1'b1;
      repeat (8) begin
        step();
        hirun = rx_o ? hirun + 1 : 0;
        if (idle_evt_o) begin ni++; ipos = hirun; end
      end
      if (b == 10) b = 70;
    end
    repeat (60) begin
      step();
      hirun = rx_o ? hirun + 1 : 0;
      if (idle_evt_o) begin ni++; ipos = hirun; end
    end
    chk("idle_count", ni, 1);
    chk("idle_pos", ipos, 16);

    // Disable in the middle of a break, then re-enable
    rx_i = 0; repeat (40) step();
    chk("dis_brk_on", break_o, 1);
    cfg_en_i = 0; step();
    chk("dis_rx", rx_o, 1);
    chk("dis_brk", break_o, 0);
    chk("dis_evt", {break_evt_o, idle_evt_o}, 0);
    repeat (5) step();
    cfg_en_i = 1; lowcnt = 0; bpos = 0;
    repeat (40) begin
      step();
      if (!rx_o) lowcnt++;
      if (break_evt_o) bpos = lowcnt;
    end
    chk("reen_brk_pos", bpos, 20);
    rx_i = 1; repeat (10) step();

    // Randomised traffic, config changes, enable drops, clears and resets
    run_left = 0; lvl = 1;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lvl = $urandom_range(0, 1);
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 25);
      end
      rx_i = lvl;
      run_left--;
      if (i % 250 == 0) begin
        cfg_filt_len_i  = $urandom_range(0, 5);
        cfg_break_len_i = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
        cfg_idle_len_i  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      end
      cfg_en_i     = ($urandom_range(0, 150) != 0);
      glitch_clr_i = ($urandom_range(0, 99) == 0);
      rstn_i       = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
